// File: rtl/sap_cpu_gen2_pkg.sv
// sap_pkg: shared definitions for the sap_cpu_gen2 accumulator CPU.
//   opcode_t        4-bit instruction opcodes (top nibble of the opcode word)
//   state_t         instruction-sequencer states
//   FLAG_Z, FLAG_C  bit positions inside the flag register
//   needs_operand() opcode is followed by an operand word
//   needs_mem()     opcode dereferences its operand as a RAM address
package sap_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_LDA   = 4'h1,
      OP_ADD   = 4'h2,
      OP_SUB   = 4'h3,
      OP_STA   = 4'h4,
      OP_LDI   = 4'h5,
      OP_JMP   = 4'h6,
      OP_JC    = 4'h7,
      OP_JZ    = 4'h8,
      OP_AND   = 4'h9,
      OP_OR    = 4'hA,
      OP_XOR   = 4'hB,
      OP_RSV_C = 4'hC,
      OP_RSV_D = 4'hD,
      OP_OUT   = 4'hE,
      OP_HLT   = 4'hF
   } opcode_t;

   typedef enum logic [2:0] {
      S_F_ADDR,
      S_F_INSTR,
      S_O_ADDR,
      S_O_DATA,
      S_X_ADDR,
      S_X_EXEC,
      S_HALT
   } state_t;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;

   function automatic logic needs_operand(input opcode_t op);
      return (op inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP, OP_JC,
                         OP_JZ, OP_AND, OP_OR, OP_XOR, OP_OUT});
   endfunction

   function automatic logic needs_mem(input opcode_t op);
      return (op inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_AND, OP_OR, OP_XOR});
   endfunction

endpackage

// File: rtl/sap_cpu_gen2_if.sv
// sap_cpu_gen2_if: program-load port and output bus of sap_cpu_gen2.
//   prog_we/prog_addr/prog_data  RAM load port (driven by the master)
//   out       packed output registers, channel k at [k*DATA_W +: DATA_W]
//   out_valid one-cycle write pulse per channel
//   halted    CPU has executed HLT
interface sap_cpu_gen2_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int OUT_CH = 2
);
   logic                     prog_we;
   logic [ADDR_W-1:0]        prog_addr;
   logic [DATA_W-1:0]        prog_data;
   logic [OUT_CH*DATA_W-1:0] out;
   logic [OUT_CH-1:0]        out_valid;
   logic                     halted;

   modport master (
      output prog_we, prog_addr, prog_data,
      input  out, out_valid, halted
   );

   modport slave (
      input  prog_we, prog_addr, prog_data,
      output out, out_valid, halted
   );
endinterface

// File: rtl/sap_cpu_gen2_alu.sv
// sap_alu: combinational ALU for sap_cpu_gen2.
//   a, b    accumulator and memory operand
//   op      opcode selecting ADD/SUB/AND/OR/XOR (others pass b through)
//   result  DATA_W-bit result
//   c       carry out of the DATA_W+1-bit add (SUB: 1 = no borrow); 0 otherwise
//   z       result is zero
module sap_alu
   import sap_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  opcode_t           op,
   output logic [DATA_W-1:0] result,
   output logic              c,
   output logic              z
);

   logic [DATA_W:0] sum;

   always_comb begin
      sum    = '0;
      result = b;
      c      = 1'b0;
      case (op)
         OP_ADD: begin
            sum    = {1'b0, a} + {1'b0, b};
            result = sum[DATA_W-1:0];
            c      = sum[DATA_W];
         end
         OP_SUB: begin
            // two's-complement subtract keeps the carry as "no borrow"
            sum    = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
            result = sum[DATA_W-1:0];
            c      = sum[DATA_W];
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         default: ;
      endcase
      z = (result == '0);
   end

endmodule

// File: rtl/sap_cpu_gen2.sv
// sap_cpu_gen2: SAP-style accumulator CPU with unified program/data RAM and
// two-word instructions (opcode word, operand word).
//   clk, reset  clock; asynchronous active-high reset (RAM is not cleared)
//   run         1 = execute, 0 = freeze architectural state / allow RAM loads
//   bus         sap_cpu_gen2_if.slave: load port, out, out_valid, halted
// Optional build macro SAP_TRACE_EN adds retire / retire_pc / retire_op.
//
// state     | meaning
// F_ADDR    | MAR <= PC
// F_INSTR   | IR <= mem[MAR], PC++
// O_ADDR    | MAR <= PC
// O_DATA    | OPR <= mem[MAR], PC++
// X_ADDR    | MAR <= OPR (memory-operand instructions only)
// X_EXEC    | execute, retire instruction
// HALT      | terminal until reset
module sap_cpu_gen2
   import sap_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int OUT_CH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   sap_cpu_gen2_if.slave     bus
`ifdef SAP_TRACE_EN
   ,
   output logic              retire,
   output logic [ADDR_W-1:0] retire_pc,
   output logic [3:0]        retire_op
`endif
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]        mem [DEPTH];
   state_t                   state, state_nx;
   logic [ADDR_W-1:0]        pc, mar;
   opcode_t                  ir;
   logic [DATA_W-1:0]        opr, a;
   logic [1:0]               flags;
   logic [OUT_CH*DATA_W-1:0] out_q;
   logic [OUT_CH-1:0]        valid_q;

   logic [DATA_W-1:0]        mem_rd;
   opcode_t                  op_fetch;
   logic [DATA_W-1:0]        alu_res;
   logic                     alu_c, alu_z;
   logic [DATA_W-1:0]        ch_idx;

   assign mem_rd   = mem[mar];
   assign op_fetch = opcode_t'(mem_rd[DATA_W-1 -: 4]);
   assign ch_idx   = opr % DATA_W'(OUT_CH);

   sap_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (a),
      .b      (mem_rd),
      .op     (ir),
      .result (alu_res),
      .c      (alu_c),
      .z      (alu_z)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_F_ADDR;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (run) begin
         case (state)
            S_F_ADDR:  state_nx = S_F_INSTR;
            S_F_INSTR: state_nx = needs_operand(op_fetch) ? S_O_ADDR : S_X_EXEC;
            S_O_ADDR:  state_nx = S_O_DATA;
            S_O_DATA:  state_nx = needs_mem(ir) ? S_X_ADDR : S_X_EXEC;
            S_X_ADDR:  state_nx = S_X_EXEC;
            S_X_EXEC:  state_nx = (ir == OP_HLT) ? S_HALT : S_F_ADDR;
            S_HALT:    state_nx = S_HALT;
            default:   state_nx = S_F_ADDR;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= '0;
         mar     <= '0;
         ir      <= OP_NOP;
         opr     <= '0;
         a       <= '0;
         flags   <= '0;
         out_q   <= '0;
         valid_q <= '0;
      end else if (run) begin
         // a pending out_valid pulse is only retired by a running cycle
         valid_q <= '0;
         case (state)
            S_F_ADDR:  mar <= pc;
            S_F_INSTR: begin
               ir <= op_fetch;
               pc <= pc + 1'b1;
            end
            S_O_ADDR:  mar <= pc;
            S_O_DATA:  begin
               opr <= mem_rd;
               pc  <= pc + 1'b1;
            end
            S_X_ADDR:  mar <= opr[ADDR_W-1:0];
            S_X_EXEC:  begin
               case (ir)
                  OP_LDA: a <= mem_rd;
                  OP_LDI: a <= opr;
                  OP_ADD, OP_SUB: begin
                     a            <= alu_res;
                     flags[FLAG_C] <= alu_c;
                     flags[FLAG_Z] <= alu_z;
                  end
                  OP_AND, OP_OR, OP_XOR: begin
                     a            <= alu_res;
                     flags[FLAG_C] <= 1'b0;
                     flags[FLAG_Z] <= alu_z;
                  end
                  OP_JMP: pc <= opr[ADDR_W-1:0];
                  OP_JC:  if (flags[FLAG_C]) pc <= opr[ADDR_W-1:0];
                  OP_JZ:  if (flags[FLAG_Z]) pc <= opr[ADDR_W-1:0];
                  OP_OUT: begin
                     for (int k = 0; k < OUT_CH; k++) begin
                        if (ch_idx == DATA_W'(k)) begin
                           out_q[k*DATA_W +: DATA_W] <= a;
                           valid_q[k]                <= 1'b1;
                        end
                     end
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // RAM: load port while frozen, STA while running; contents survive reset
   always_ff @(posedge clk) begin
      if (!run && bus.prog_we)
         mem[bus.prog_addr] <= bus.prog_data;
      else if (run && state == S_X_EXEC && ir == OP_STA)
         mem[mar] <= a;
   end

   assign bus.out       = out_q;
   assign bus.out_valid = run ? valid_q : '0;
   assign bus.halted    = (state == S_HALT);

`ifdef SAP_TRACE_EN
   logic [ADDR_W-1:0] instr_pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           instr_pc <= '0;
      else if (run && state == S_F_ADDR)   instr_pc <= pc;
   end

   assign retire    = run && (state == S_X_EXEC);
   assign retire_pc = instr_pc;
   assign retire_op = ir;
`endif

endmodule

// File: tb/tb_sap_cpu_gen2.sv
module tb_sap_cpu_gen2;
   import sap_pkg::*;

   localparam int MAXC = 120;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic run8 = 1'b0;
   logic run16 = 1'b0;

   always #5 clk = ~clk;

   sap_cpu_gen2_if #(.DATA_W(8),  .ADDR_W(8), .OUT_CH(2)) if8 ();
   sap_cpu_gen2_if #(.DATA_W(16), .ADDR_W(4), .OUT_CH(2)) if16 ();

`ifdef SAP_TRACE_EN
   logic       ret8, ret16;
   logic [7:0] rpc8;
   logic [3:0] rpc16, rop8, rop16;
`endif

   sap_cpu_gen2 #(.DATA_W(8), .ADDR_W(8), .OUT_CH(2)) dut8 (
      .clk   (clk),
      .reset (reset),
      .run   (run8),
      .bus   (if8)
`ifdef SAP_TRACE_EN
      , .retire(ret8), .retire_pc(rpc8), .retire_op(rop8)
`endif
   );

   sap_cpu_gen2 #(.DATA_W(16), .ADDR_W(4), .OUT_CH(2)) dut16 (
      .clk   (clk),
      .reset (reset),
      .run   (run16),
      .bus   (if16)
`ifdef SAP_TRACE_EN
      , .retire(ret16), .retire_pc(rpc16), .retire_op(rop16)
`endif
   );

   logic [15:0] img [256];
   logic [15:0] exp_out   [MAXC+1][2];
   logic [1:0]  exp_valid [MAXC+1];
   logic        exp_halt  [MAXC+1];

   int cmp_count = 0;
   int err_count = 0;
   int ecount = 0;
   int npulse = 0;
   int last_e = -1;
   bit active = 1'b0;
   int sel = 0;
   logic run_cur;

   assign run_cur = (sel != 0) ? run16 : run8;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_count++;
      if (act !== exp) begin
         err_count++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction-level reference: walks the program one instruction at a
   // time, charging each its documented latency, and records what the
   // outputs must be after every counted run edge.
   task automatic model(input int dw, input int aw);
      int mm [256];
      int pc, a, c, z, t, op, opr, adr, mv, lat, s, ch, dmask, amask;
      bit halt;
      dmask = (1 << dw) - 1;
      amask = (1 << aw) - 1;
      for (int i = 0; i < 256; i++) mm[i] = int'(img[i]);
      for (int e = 0; e <= MAXC; e++) begin
         exp_out[e][0] = '0;
         exp_out[e][1] = '0;
         exp_valid[e]  = '0;
         exp_halt[e]   = 1'b0;
      end
      pc = 0; a = 0; c = 0; z = 0; t = 0; halt = 1'b0;
      while (!halt && t < MAXC) begin
         op  = (mm[pc] >> (dw - 4)) & 15;
         pc  = (pc + 1) & amask;
         lat = 3;
         opr = 0;
         if ((op >= 1 && op <= 11) || op == 14) begin
            opr = mm[pc];
            pc  = (pc + 1) & amask;
            lat = 5;
            if ((op >= 1 && op <= 4) || (op >= 9 && op <= 11)) lat = 6;
         end
         adr = opr & amask;
         mv  = mm[adr];
         t   = t + lat;
         case (op)
            1:  a = mv;
            2:  begin s = a + mv;                 c = (s >> dw) & 1; a = s & dmask; z = (a == 0); end
            3:  begin s = a + ((~mv) & dmask) + 1; c = (s >> dw) & 1; a = s & dmask; z = (a == 0); end
            4:  mm[adr] = a;
            5:  a = opr;
            6:  pc = adr;
            7:  if (c != 0) pc = adr;
            8:  if (z != 0) pc = adr;
            9:  begin a = a & mv; z = (a == 0); c = 0; end
            10: begin a = a | mv; z = (a == 0); c = 0; end
            11: begin a = a ^ mv; z = (a == 0); c = 0; end
            14: begin
               ch = opr % 2;
               for (int e = t; e <= MAXC; e++) exp_out[e][ch] = 16'(a);
               if (t <= MAXC) exp_valid[t][ch] = 1'b1;
            end
            15: begin
               for (int e = t; e <= MAXC; e++) exp_halt[e] = 1'b1;
               halt = 1'b1;
            end
            default: ;
         endcase
      end
   endtask

   always @(posedge clk) begin
      if (!active)      ecount <= 0;
      else if (run_cur) ecount <= ecount + 1;
   end

   logic [15:0] o0, o1;
   logic [1:0]  ov;
   logic        oh;
   int          ei;

   always @(negedge clk) begin
      if (!active) begin
         npulse <= 0;
         last_e <= -1;
      end else begin
         ei = (ecount > MAXC) ? MAXC : ecount;
         if (sel == 0) begin
            o0 = {8'h00, if8.out[7:0]};
            o1 = {8'h00, if8.out[15:8]};
            ov = if8.out_valid;
            oh = if8.halted;
         end else begin
            o0 = if16.out[15:0];
            o1 = if16.out[31:16];
            ov = if16.out_valid;
            oh = if16.halted;
         end
         chk("out0", {16'h0, o0}, {16'h0, exp_out[ei][0]});
         chk("out1", {16'h0, o1}, {16'h0, exp_out[ei][1]});
         chk("out_valid", {30'h0, ov}, {30'h0, (run_cur ? exp_valid[ei] : 2'b00)});
         chk("halted", {31'h0, oh}, {31'h0, exp_halt[ei]});
         if (ov != 2'b00) begin
            npulse <= npulse + 1;
            last_e <= ecount;
         end
      end
   end

   task automatic go(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_img();
      for (int i = 0; i < 256; i++) img[i] = '0;
   endtask

   task automatic load8();
      for (int i = 0; i < 256; i++) begin
         if8.prog_we   = 1'b1;
         if8.prog_addr = 8'(i);
         if8.prog_data = img[i][7:0];
         go(1);
      end
      if8.prog_we = 1'b0;
   endtask

   task automatic load16();
      for (int i = 0; i < 16; i++) begin
         if16.prog_we   = 1'b1;
         if16.prog_addr = 4'(i);
         if16.prog_data = img[i];
         go(1);
      end
      if16.prog_we = 1'b0;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      go(1);
      reset = 1'b0;
      go(1);
   endtask

   task automatic start_run();
      active = 1'b1;
      if (sel == 0) run8 = 1'b1;
      else          run16 = 1'b1;
   endtask

   task automatic stop_run();
      run8  = 1'b0;
      run16 = 1'b0;
      go(1);
      active = 1'b0;
      go(1);
   endtask

   initial begin
      if8.prog_we = 1'b0;   if8.prog_addr = '0;  if8.prog_data = '0;
      if16.prog_we = 1'b0;  if16.prog_addr = '0; if16.prog_data = '0;
      reset = 1'b1;
      go(2);
      reset = 1'b0;
      go(1);
      sel = 0;
      #4;
      chk("reset_out8", {16'h0, if8.out}, 32'h0);
      chk("reset_halted8", {31'h0, if8.halted}, 32'h0);
      go(1);

      // T1: LDI 05; OUT 0; HLT
      clear_img();
      img[0] = 16'h50; img[1] = 16'h05; img[2] = 16'hE0; img[3] = 16'h00; img[4] = 16'hF0;
      load8(); reset_pulse(); model(8, 8);
      chk("model_t1_pulse_e10", {30'h0, exp_valid[10]}, 32'h1);
      chk("model_t1_halt_e12", {31'h0, exp_halt[12]}, 32'h0);
      chk("model_t1_halt_e13", {31'h0, exp_halt[13]}, 32'h1);
      start_run(); go(40);
      chk("t1_out0", {24'h0, if8.out[7:0]}, 32'h05);
      chk("t1_pulses", npulse, 1);
      chk("t1_pulse_edge", last_e, 10);
      chk("t1_halted", {31'h0, if8.halted}, 32'h1);
      stop_run();

      // T2: LDI FF; ADD [40]=01; JC 20 (taken) -> OUT 0; JZ 30 (taken) -> LDI 11; OUT 1
      clear_img();
      img[8'h00] = 16'h50; img[8'h01] = 16'hFF; img[8'h02] = 16'h20; img[8'h03] = 16'h40;
      img[8'h04] = 16'h70; img[8'h05] = 16'h20; img[8'h06] = 16'hF0;
      img[8'h20] = 16'hE0; img[8'h21] = 16'h00; img[8'h22] = 16'h80; img[8'h23] = 16'h30;
      img[8'h24] = 16'hF0;
      img[8'h30] = 16'h50; img[8'h31] = 16'h11; img[8'h32] = 16'hE0; img[8'h33] = 16'h01;
      img[8'h34] = 16'hF0; img[8'h40] = 16'h01;
      load8(); reset_pulse(); model(8, 8);
      chk("model_t2_pulse_e21", {30'h0, exp_valid[21]}, 32'h1);
      start_run(); go(60);
      chk("t2_out1", {24'h0, if8.out[15:8]}, 32'h11);
      chk("t2_pulses", npulse, 2);
      stop_run();

      // T3: LDI 03; SUB [40]=05; JC 20 (not taken); OUT 0; JZ 20 (not taken); OUT 1; HLT
      clear_img();
      img[8'h00] = 16'h50; img[8'h01] = 16'h03; img[8'h02] = 16'h30; img[8'h03] = 16'h40;
      img[8'h04] = 16'h70; img[8'h05] = 16'h20; img[8'h06] = 16'hE0; img[8'h07] = 16'h00;
      img[8'h08] = 16'h80; img[8'h09] = 16'h20; img[8'h0A] = 16'hE0; img[8'h0B] = 16'h01;
      img[8'h0C] = 16'hF0;
      img[8'h20] = 16'h50; img[8'h21] = 16'h99; img[8'h22] = 16'hE0; img[8'h23] = 16'h00;
      img[8'h24] = 16'hF0; img[8'h40] = 16'h05;
      load8(); reset_pulse(); model(8, 8);
      start_run(); go(50);
      chk("t3_out0", {24'h0, if8.out[7:0]}, 32'hFE);
      chk("t3_out1", {24'h0, if8.out[15:8]}, 32'hFE);
      chk("t3_pulse_edge", last_e, 31);
      stop_run();

      // T4: LDI FF; ADD [82]=02 (C=1,Z=0); LDI A5; STA 80; LDI 0; LDA 80; XOR [81]=A5;
      //     JZ 30 -> OUT 0; JC 40 (not taken); LDI 5A; OUT 1; HLT
      clear_img();
      img[8'h00] = 16'h50; img[8'h01] = 16'hFF; img[8'h02] = 16'h20; img[8'h03] = 16'h82;
      img[8'h04] = 16'h50; img[8'h05] = 16'hA5; img[8'h06] = 16'h40; img[8'h07] = 16'h80;
      img[8'h08] = 16'h50; img[8'h09] = 16'h00; img[8'h0A] = 16'h10; img[8'h0B] = 16'h80;
      img[8'h0C] = 16'hB0; img[8'h0D] = 16'h81; img[8'h0E] = 16'h80; img[8'h0F] = 16'h30;
      img[8'h10] = 16'hF0;
      img[8'h30] = 16'hE0; img[8'h31] = 16'h00; img[8'h32] = 16'h70; img[8'h33] = 16'h40;
      img[8'h34] = 16'h50; img[8'h35] = 16'h5A; img[8'h36] = 16'hE0; img[8'h37] = 16'h01;
      img[8'h38] = 16'hF0; img[8'h40] = 16'hF0;
      img[8'h81] = 16'hA5; img[8'h82] = 16'h02;
      load8(); reset_pulse(); model(8, 8);
      chk("model_t4_pulse_e64", {30'h0, exp_valid[64]}, 32'h2);
      start_run(); go(90);
      chk("t4_out1", {24'h0, if8.out[15:8]}, 32'h5A);
      chk("t4_pulses", npulse, 2);
      stop_run();

      // T5: LDI 3C; OUT 3 (-> ch1); LDI 10; ADD [40]; OUT 0; HLT, with stalls
      clear_img();
      img[8'h00] = 16'h50; img[8'h01] = 16'h3C; img[8'h02] = 16'hE0; img[8'h03] = 16'h03;
      img[8'h04] = 16'h50; img[8'h05] = 16'h10; img[8'h06] = 16'h20; img[8'h07] = 16'h40;
      img[8'h08] = 16'hE0; img[8'h09] = 16'h00; img[8'h0A] = 16'hF0; img[8'h40] = 16'h05;
      load8(); reset_pulse();
      img[8'h40] = 16'h07;  // rewritten during the mid-ADD stall below
      model(8, 8);
      chk("model_t5_pulse_e10", {30'h0, exp_valid[10]}, 32'h2);
      start_run(); go(5);
      if8.prog_we = 1'b1; if8.prog_addr = 8'h0A; if8.prog_data = 8'h00;  // must be ignored
      go(1);
      if8.prog_we = 1'b0;
      go(4);
      run8 = 1'b0; go(3); run8 = 1'b1;
      go(7);
      run8 = 1'b0;
      if8.prog_we = 1'b1; if8.prog_addr = 8'h40; if8.prog_data = 8'h07;
      go(1);
      if8.prog_we = 1'b0;
      go(4);
      chk("t5_stall_ecount", ecount, 17);
      chk("t5_stall_out0", {24'h0, if8.out[7:0]}, 32'h00);
      chk("t5_stall_out1", {24'h0, if8.out[15:8]}, 32'h3C);
      run8 = 1'b1;
      go(40);
      chk("t5_out0", {24'h0, if8.out[7:0]}, 32'h17);
      chk("t5_halted", {31'h0, if8.halted}, 32'h1);
      stop_run();

      // reset mid-instruction, then rerun from retained RAM
      reset_pulse(); model(8, 8);
      start_run(); go(13);
      active = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_out", {16'h0, if8.out}, 32'h0);
      chk("rst_valid", {30'h0, if8.out_valid}, 32'h0);
      chk("rst_halted", {31'h0, if8.halted}, 32'h0);
      run8 = 1'b0;
      go(1);
      reset = 1'b0;
      go(1);
      start_run(); go(40);
      chk("rerun_out0", {24'h0, if8.out[7:0]}, 32'h17);
      chk("rerun_out1", {24'h0, if8.out[15:8]}, 32'h3C);
      stop_run();

      // T6: 16-bit/4-bit DUT: JMP 0F onto LDI whose operand wraps to mem[0]
      sel = 1;
      clear_img();
      img[0] = 16'h6000; img[1] = 16'h000F; img[2] = 16'hE000; img[3] = 16'h0000;
      img[4] = 16'hF000; img[15] = 16'h5000;
      load16(); reset_pulse(); model(16, 4);
      chk("model_t6_pulse_e18", {30'h0, exp_valid[18]}, 32'h1);
      start_run(); go(40);
      chk("t6_out0", {16'h0, if16.out[15:0]}, 32'h6000);
      chk("t6_pulse_edge", last_e, 18);
      chk("t6_halted", {31'h0, if16.halted}, 32'h1);
      stop_run();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
